apb_initiator: RTL and testbench
================================

Name: apb_initiator

Overview:
APB3 initiator (requester side) that turns a simple valid/ready command stream into single APB transfers.
- Targets APB responders such as the VGA character/colour-map slave, which runs on the same clock.
- Used by loader and test logic to write and read char/colour maps without a CPU.
- Handles one outstanding transfer at a time, with a response channel and an access timeout.

Parameters:
APB_ADDR_WIDTH, 14, width of apb_paddr_o and req_addr_i
APB_DATA_WIDTH, 32, width of the data buses
TIMEOUT_CYCLES, 16, maximum ACCESS-phase cycles before abort; 0 disables the timeout
CNT_WIDTH, 8, width of the timeout counter; must satisfy TIMEOUT_CYCLES < 2**CNT_WIDTH

Ports:
clk_i  in  1  single clock
rstn_i  in  1  asynchronous active-low reset
req_valid_i  in  1  command valid
req_ready_o  out  1  command accepted when valid&ready
req_write_i  in  1  1=write, 0=read
req_addr_i  in  APB_ADDR_WIDTH  byte address
req_wdata_i  in  APB_DATA_WIDTH  write data
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed when valid&ready
rsp_rdata_o  out  APB_DATA_WIDTH  read data; 0 for writes and timeouts
rsp_err_o  out  1  pslverr captured, or timeout
rsp_timeout_o  out  1  transfer aborted by the timeout
apb_paddr_o  out  APB_ADDR_WIDTH  APB address
apb_pwdata_o  out  APB_DATA_WIDTH  APB write data
apb_pwrite_o  out  1  APB direction
apb_psel_o  out  1  APB select
apb_penable_o  out  1  APB enable
apb_prdata_i  in  APB_DATA_WIDTH  APB read data
apb_pready_i  in  1  APB ready
apb_pslverr_i  in  1  APB error

Behaviour:
- Reset (async, rstn_i low) forces all outputs to 0 and the FSM to IDLE, including in the middle of a transfer. No response is generated for an aborted transfer.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, register addr (bits [1:0] forced to 0), wdata and write, then go to SETUP.
- SETUP (exactly 1 cycle):
  - psel=1, penable=0; paddr, pwrite and pwdata come from the registered command.
  - Clear the timeout counter, then go to ACCESS.
- ACCESS:
  - psel=1, penable=1; paddr, pwdata and pwrite are held stable.
  - If pready=1 in a cycle: capture prdata (reads only; writes capture 0) and pslverr into the response registers, then go to RESP.
  - Otherwise increment the counter.
  - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES with pready still 0: drop psel/penable, set rsp_err=1, rsp_timeout=1, rdata=0, and go to RESP.
  - pready and timeout in the same cycle: pready wins, no timeout.
- RESP:
  - rsp_valid_o=1 with the payload held stable; psel=0, penable=0.
  - On rsp_ready_i go to IDLE.
  - req_ready_o=0 throughout, so there is no overlap; the next SETUP can come no earlier than 2 cycles after the response handshake.
- req_ready_o is 0 outside IDLE. Commands presented then are held by the requester, not dropped.
- Minimum latency with a zero-wait responder: accept at cycle T, SETUP T+1, ACCESS T+2 (pready=1), rsp_valid at T+3.
- Each extra wait state adds 1 cycle.
- The counter saturates and never wraps.
- Outside SETUP/ACCESS: paddr and pwdata hold their last values; pwrite holds its value.

Test Plan:
- Write, zero-wait responder: req write addr=0x0004 data=0xDEADBEEF → psel at T+1, penable at T+2 with paddr=0x0004 and pwdata=0xDEADBEEF; rsp_valid at T+3 with err=0, rdata=0.
- Read, 2 wait states (matches the VGA slave): prdata=0x12345678 with pready high on the 3rd ACCESS cycle → rsp_rdata=0x12345678 at T+5; paddr stable throughout ACCESS.
- Unaligned address 0x0963 → paddr=0x0960. pslverr=1 with pready → rsp_err=1, rsp_timeout=0.
- Timeout: pready held 0, TIMEOUT_CYCLES=16 → exactly 16 ACCESS cycles, then psel=0 and rsp_valid with err=1, timeout=1, rdata=0.
- Response backpressure: rsp_ready=0 for 5 cycles with req_valid held high → req_ready stays 0, payload stable; the second command is accepted 1 cycle after the response handshake.
- Reset mid-ACCESS: rstn_i low → psel, penable, rsp_valid and req_ready all 0 immediately. After release, req_ready=1 and no response is emitted.

Source files
------------

// File: rtl/apb_initiator.sv
// APB3 initiator: turns a valid/ready command stream into single APB transfers,
// one outstanding at a time, with a response channel and an ACCESS-phase timeout.
module apb_initiator #(
  parameter int APB_ADDR_WIDTH = 14,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_write_i,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [APB_DATA_WIDTH-1:0] req_wdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [APB_DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      rsp_timeout_o,
  output logic [APB_ADDR_WIDTH-1:0] apb_paddr_o,
  output logic [APB_DATA_WIDTH-1:0] apb_pwdata_o,
  output logic                      apb_pwrite_o,
  output logic                      apb_psel_o,
  output logic                      apb_penable_o,
  input  logic [APB_DATA_WIDTH-1:0] apb_prdata_i,
  input  logic                      apb_pready_i,
  input  logic                      apb_pslverr_i
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  // Counter value seen on the last permitted ACCESS cycle.
  localparam logic [CNT_WIDTH-1:0] LP_CNT_LAST =
    (TIMEOUT_CYCLES == 0) ? {CNT_WIDTH{1'b0}} : CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                    r_state;
  state_t                    w_state_next;
  logic [APB_ADDR_WIDTH-1:0] r_addr;
  logic [APB_DATA_WIDTH-1:0] r_wdata;
  logic                      r_write;
  logic [CNT_WIDTH-1:0]      r_cnt;
  logic [APB_DATA_WIDTH-1:0] r_rdata;
  logic                      r_err;
  logic                      r_timeout;
  logic                      w_accept;
  logic                      w_timeout;

  assign w_accept  = (r_state == S_IDLE) && req_valid_i;
  // pready has priority: a transfer completing on its last allowed cycle is not a timeout.
  assign w_timeout = (TIMEOUT_CYCLES != 0) && !apb_pready_i && (r_cnt == LP_CNT_LAST);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (req_valid_i) w_state_next = S_SETUP;
      S_SETUP:  w_state_next = S_ACCESS;
      S_ACCESS: if (apb_pready_i || w_timeout) w_state_next = S_RESP;
      S_RESP:   if (rsp_ready_i) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_write   <= 1'b0;
      r_cnt     <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_addr  <= {req_addr_i[APB_ADDR_WIDTH-1:2], 2'b00};
        r_wdata <= req_wdata_i;
        r_write <= req_write_i;
      end
      if (r_state == S_SETUP) begin
        r_cnt <= '0;
      end else if (r_state == S_ACCESS) begin
        if (apb_pready_i) begin
          r_rdata   <= r_write ? '0 : apb_prdata_i;
          r_err     <= apb_pslverr_i;
          r_timeout <= 1'b0;
        end else if (w_timeout) begin
          r_rdata   <= '0;
          r_err     <= 1'b1;
          r_timeout <= 1'b1;
        end else if (r_cnt != {CNT_WIDTH{1'b1}}) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  // Gated with reset so the requester sees no readiness while held in reset.
  assign req_ready_o   = rstn_i && (r_state == S_IDLE);
  assign apb_psel_o    = (r_state == S_SETUP) || (r_state == S_ACCESS);
  assign apb_penable_o = (r_state == S_ACCESS);
  assign apb_paddr_o   = r_addr;
  assign apb_pwdata_o  = r_wdata;
  assign apb_pwrite_o  = r_write;
  assign rsp_valid_o   = (r_state == S_RESP);
  assign rsp_rdata_o   = r_rdata;
  assign rsp_err_o     = r_err;
  assign rsp_timeout_o = r_timeout;

endmodule

// File: tb/tb_apb_initiator.sv
// Bench for apb_initiator: directed commands against a configurable APB responder,
// a per-cycle transaction-timeline model, and literal latency/payload expectations.
module tb_apb_initiator;
  localparam int AW = 14;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk_i = 1'b0;
  logic          rstn_i = 1'b0;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic          req_write_i = 1'b0;
  logic [AW-1:0] req_addr_i = '0;
  logic [DW-1:0] req_wdata_i = '0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b0;
  logic [DW-1:0] rsp_rdata_o;
  logic          rsp_err_o;
  logic          rsp_timeout_o;
  logic [AW-1:0] apb_paddr_o;
  logic [DW-1:0] apb_pwdata_o;
  logic          apb_pwrite_o;
  logic          apb_psel_o;
  logic          apb_penable_o;
  logic [DW-1:0] apb_prdata_i;
  logic          apb_pready_i;
  logic          apb_pslverr_i;

  apb_initiator #(
    .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(8)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
    .apb_paddr_o(apb_paddr_o), .apb_pwdata_o(apb_pwdata_o), .apb_pwrite_o(apb_pwrite_o),
    .apb_psel_o(apb_psel_o), .apb_penable_o(apb_penable_o),
    .apb_prdata_i(apb_prdata_i), .apb_pready_i(apb_pready_i), .apb_pslverr_i(apb_pslverr_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Responder: pready on ACCESS cycle number cfg_waits+1 of the current transfer.
  int          cfg_waits = 0;
  logic        cfg_err = 1'b0;
  logic [DW-1:0] cfg_rdata = '0;
  int          acc_cnt = 0;
  always @(posedge clk_i) begin
    if (apb_psel_o && apb_penable_o && !apb_pready_i) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end
  assign apb_pready_i  = apb_psel_o && apb_penable_o && (acc_cnt == cfg_waits);
  assign apb_pslverr_i = apb_pready_i && cfg_err;
  assign apb_prdata_i  = cfg_rdata;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: a transfer is a timeline of phases counted from the accept cycle.
  logic          m_busy = 1'b0;
  int            m_phase = 0;
  int            m_acc = 0;
  logic          m_wr = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rd = '0;
  logic          m_err = 1'b0;
  logic          m_to = 1'b0;
  int            acc_seen = 0;
  logic [AW-1:0] acc_paddr = '0;
  logic [DW-1:0] acc_pwdata = '0;

  initial begin
    logic in_setup, in_acc, in_resp;
    forever begin
      @(negedge clk_i);
      if (!rstn_i) begin
        chk("rst_req_ready", 32'(req_ready_o), 0);
        chk("rst_psel", 32'(apb_psel_o), 0);
        chk("rst_penable", 32'(apb_penable_o), 0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 0);
        chk("rst_paddr", 32'(apb_paddr_o), 0);
        chk("rst_pwdata", apb_pwdata_o, 0);
        chk("rst_pwrite", 32'(apb_pwrite_o), 0);
        chk("rst_rdata", rsp_rdata_o, 0);
        chk("rst_err", 32'(rsp_err_o), 0);
        chk("rst_timeout", 32'(rsp_timeout_o), 0);
        m_busy = 1'b0; m_addr = '0; m_wdata = '0; m_wr = 1'b0;
      end else begin
        in_setup = m_busy && (m_phase == 1);
        in_acc   = m_busy && (m_phase >= 2) && (m_phase <= 1 + m_acc);
        in_resp  = m_busy && (m_phase >= 2 + m_acc);
        chk("req_ready", 32'(req_ready_o), 32'(!m_busy));
        chk("psel", 32'(apb_psel_o), 32'(in_setup || in_acc));
        chk("penable", 32'(apb_penable_o), 32'(in_acc));
        chk("rsp_valid", 32'(rsp_valid_o), 32'(in_resp));
        chk("paddr", 32'(apb_paddr_o), 32'(m_addr));
        chk("pwdata", apb_pwdata_o, m_wdata);
        chk("pwrite", 32'(apb_pwrite_o), 32'(m_wr));
        if (in_resp) begin
          chk("rsp_rdata", rsp_rdata_o, m_rd);
          chk("rsp_err", 32'(rsp_err_o), 32'(m_err));
          chk("rsp_timeout", 32'(rsp_timeout_o), 32'(m_to));
        end
        if (apb_psel_o && !apb_penable_o) acc_seen = 0;
        if (apb_psel_o && apb_penable_o) begin
          acc_seen++;
          acc_paddr = apb_paddr_o;
          acc_pwdata = apb_pwdata_o;
        end
        if (m_busy) begin
          if (in_resp && rsp_ready_i) m_busy = 1'b0;
          else m_phase++;
        end else if (req_valid_i) begin
          m_busy  = 1'b1;
          m_phase = 1;
          m_wr    = req_write_i;
          m_addr  = req_addr_i & ~AW'(3);
          m_wdata = req_wdata_i;
          m_to    = (cfg_waits >= TO);
          m_acc   = m_to ? TO : cfg_waits + 1;
          m_err   = m_to || cfg_err;
          m_rd    = (m_wr || m_to) ? '0 : cfg_rdata;
        end
      end
    end
  end

  task automatic wait_for(input bit want_rsp, output int c);
    int n;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!(want_rsp ? rsp_valid_o : req_ready_o) && n < 200);
    chk(want_rsp ? "wait_rsp_valid" : "wait_req_ready",
        32'(want_rsp ? rsp_valid_o : req_ready_o), 1);
    c = cyc;
  endtask

  task automatic do_txn(input string tag, input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input int waits, input logic perr,
                        input logic [DW-1:0] prd, output int lat, output logic [DW-1:0] rd,
                        output logic e, output logic to);
    int t0, t1;
    cfg_waits = waits; cfg_err = perr; cfg_rdata = prd;
    @(posedge clk_i); #1;
    req_valid_i = 1'b1; req_write_i = wr; req_addr_i = addr; req_wdata_i = wd;
    rsp_ready_i = 1'b1;
    wait_for(1'b0, t0);
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    wait_for(1'b1, t1);
    lat = t1 - t0; rd = rsp_rdata_o; e = rsp_err_o; to = rsp_timeout_o;
    $display("txn %s wr=%0d addr=0x%04h lat=%0d access=%0d rdata=0x%08h err=%0d to=%0d",
             tag, wr, addr, lat, acc_seen, rd, e, to);
    @(posedge clk_i); #1;
  endtask

  initial begin
    int lat, t0, t1, t2;
    logic [DW-1:0] rd;
    logic e, to;

    repeat (3) @(posedge clk_i);
    #1 rstn_i = 1'b1;
    @(negedge clk_i);
    chk("post_reset_req_ready", 32'(req_ready_o), 1);

    do_txn("wr0", 1'b1, 14'h0004, 32'hDEADBEEF, 0, 1'b0, 32'hAAAA5555, lat, rd, e, to);
    chk("wr0_latency", lat, 3);
    chk("wr0_access_cycles", acc_seen, 1);
    chk("wr0_paddr", 32'(acc_paddr), 32'h0004);
    chk("wr0_pwdata", acc_pwdata, 32'hDEADBEEF);
    chk("wr0_rdata", rd, 0);
    chk("wr0_err", 32'(e), 0);

    do_txn("rd2w", 1'b0, 14'h0100, 32'h0, 2, 1'b0, 32'h12345678, lat, rd, e, to);
    chk("rd2w_latency", lat, 5);
    chk("rd2w_access_cycles", acc_seen, 3);
    chk("rd2w_rdata", rd, 32'h12345678);

    do_txn("unal", 1'b0, 14'h0963, 32'h0, 0, 1'b1, 32'hCAFEF00D, lat, rd, e, to);
    chk("unal_paddr", 32'(acc_paddr), 32'h0960);
    chk("unal_err", 32'(e), 1);
    chk("unal_timeout", 32'(to), 0);

    do_txn("tmo", 1'b0, 14'h0010, 32'h0, 255, 1'b0, 32'h55AA55AA, lat, rd, e, to);
    chk("tmo_latency", lat, 18);
    chk("tmo_access_cycles", acc_seen, 16);
    chk("tmo_err", 32'(e), 1);
    chk("tmo_timeout", 32'(to), 1);
    chk("tmo_rdata", rd, 0);

    do_txn("last", 1'b0, 14'h0020, 32'h0, 15, 1'b0, 32'h0BADCAFE, lat, rd, e, to);
    chk("last_latency", lat, 18);
    chk("last_timeout", 32'(to), 0);
    chk("last_rdata", rd, 32'h0BADCAFE);

    do_txn("wrerr", 1'b1, 14'h3FFF, 32'h01234567, 1, 1'b1, 32'hFFFFFFFF, lat, rd, e, to);
    chk("wrerr_rdata", rd, 0);
    chk("wrerr_err", 32'(e), 1);

    // Response backpressure with the next command already waiting.
    cfg_waits = 0; cfg_err = 1'b0; cfg_rdata = 32'h0;
    @(posedge clk_i); #1;
    req_valid_i = 1'b1; req_write_i = 1'b1; req_addr_i = 14'h0030; req_wdata_i = 32'h11112222;
    rsp_ready_i = 1'b0;
    wait_for(1'b0, t0);
    @(posedge clk_i); #1;
    req_addr_i = 14'h0034; req_wdata_i = 32'h33334444;
    wait_for(1'b1, t1);
    repeat (5) @(posedge clk_i);
    #1 rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b0;
    wait_for(1'b0, t2);
    chk("bp_accept_gap", t2 - (t1 + 5), 1);
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    wait_for(1'b1, t1);
    chk("bp_second_latency", t1 - t2, 3);
    chk("bp_second_pwdata", acc_pwdata, 32'h33334444);
    $display("txn bp second accepted at cycle %0d, response at %0d", t2, t1);
    @(posedge clk_i); #1 rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;

    // Reset in the middle of ACCESS: everything drops, no response afterwards.
    cfg_waits = 255;
    req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 14'h0040;
    wait_for(1'b0, t0);
    @(posedge clk_i); #1 req_valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rstn_i = 1'b0;
    #1;
    chk("midrst_psel", 32'(apb_psel_o), 0);
    chk("midrst_penable", 32'(apb_penable_o), 0);
    chk("midrst_rsp_valid", 32'(rsp_valid_o), 0);
    chk("midrst_req_ready", 32'(req_ready_o), 0);
    repeat (2) @(posedge clk_i);
    #1 rstn_i = 1'b1;
    @(negedge clk_i);
    chk("midrst_release_req_ready", 32'(req_ready_o), 1);
    repeat (20) @(negedge clk_i);
    chk("midrst_no_response", 32'(rsp_valid_o), 0);
    $display("txn midrst aborted read at 0x0040, accepted cycle %0d", t0);

    do_txn("after", 1'b0, 14'h0044, 32'h0, 0, 1'b0, 32'h87654321, lat, rd, e, to);
    chk("after_latency", lat, 3);
    chk("after_rdata", rd, 32'h87654321);

    repeat (3) @(posedge clk_i);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
